// File: rtl/joypad_p1.sv
// P1 (0xFF00) joypad receiver: synchronizes and debounces eight active-low button
// lines, exposes them through the DMG group-select register, and raises the joypad IRQ.
module joypad_p1 #(
  parameter int DEBOUNCE_CYCLES = 4190,
  parameter int CNT_W           = 16
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        joypad_up,
  input  logic        joypad_down,
  input  logic        joypad_left,
  input  logic        joypad_right,
  input  logic        joypad_a,
  input  logic        joypad_b,
  input  logic        joypad_start,
  input  logic        joypad_select,
  input  logic [15:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        joy_irq
);

  localparam logic [15:0]      P1_ADDR = 16'hFF00;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: [3:0] directions {down, up, left, right}, [7:4] buttons {start, select, b, a}.
  logic [7:0]       raw;
  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       db;
  logic [CNT_W-1:0] cnt [8];
  logic [1:0]       sel;
  logic [3:0]       dir_grp;
  logic [3:0]       btn_grp;
  logic [3:0]       nib;
  logic [3:0]       nib_q;
  logic [7:0]       p1;
  logic             wr_hit;
  logic             rd_hit;
  logic             unused_data;

  assign raw = {joypad_start, joypad_select, joypad_b, joypad_a,
                joypad_down, joypad_up, joypad_left, joypad_right};

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so sync1 -> sync2
  // forms a real two-stage chain and a same-cycle read sees the pre-write sel.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      db <= '1;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A low select bit enables its group; unselected groups read as released.
  assign dir_grp = sel[0] ? 4'hF : db[3:0];
  assign btn_grp = sel[1] ? 4'hF : db[7:4];
  assign nib     = dir_grp & btn_grp;
  assign p1      = {2'b11, sel, nib};

  assign wr_hit      = wr_en && (addr == P1_ADDR);
  assign rd_hit      = rd_en && (addr == P1_ADDR);
  assign unused_data = ^{data_in[7:6], data_in[3:0]};

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      sel      <= 2'b11;
      nib_q    <= 4'hF;
      data_out <= 8'hFF;
      joy_irq  <= 1'b0;
    end else begin
      data_out <= rd_hit ? p1 : 8'hFF;
      if (wr_hit) sel <= data_in[5:4];
      nib_q   <= nib;
      joy_irq <= |(nib_q & ~nib);
    end
  end

endmodule

// File: tb/tb_joypad_p1.sv
// Self-checking bench for joypad_p1: a per-cycle behavioural model compared every
// cycle, plus directed reads and IRQ checks against hand-computed literals.
module tb_joypad_p1;

  localparam int DB   = 4;
  localparam int R_RT = 0, R_LF = 1, R_UP = 2, R_DN = 3;
  localparam int B_A  = 4, B_B  = 5, B_SE = 6, B_ST = 7;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic [7:0]  btn;
  logic [15:0] addr;
  logic        rd_en, wr_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        joy_irq;

  int n_cmp = 0;
  int n_bad = 0;

  joypad_p1 #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .joypad_up    (btn[R_UP]),
    .joypad_down  (btn[R_DN]),
    .joypad_left  (btn[R_LF]),
    .joypad_right (btn[R_RT]),
    .joypad_a     (btn[B_A]),
    .joypad_b     (btn[B_B]),
    .joypad_start (btn[B_ST]),
    .joypad_select(btn[B_SE]),
    .addr         (addr),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .joy_irq      (joy_irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] raw_q[$];
  bit [7:0] seen_q[$];
  bit [7:0] m_db;
  bit [1:0] m_sel;
  bit [3:0] m_nib_prev;
  bit [7:0] m_dout;
  bit       m_irq;
  bit       m_valid = 1'b0;

  function automatic bit [3:0] nib_of(input bit [7:0] d, input bit [1:0] s);
    bit [3:0] dirs;
    bit [3:0] btns;
    dirs = {d[R_DN], d[R_UP], d[R_LF], d[R_RT]};
    btns = {d[B_ST], d[B_SE], d[B_B], d[B_A]};
    return (s[0] ? 4'hF : dirs) & (s[1] ? 4'hF : btns);
  endfunction

  always @(posedge cpu_clk) begin : model
    bit [3:0] cur;
    bit [7:0] seen;
    bit       all_diff;
    if (rst) begin
      raw_q.delete();
      seen_q.delete();
      m_db       = 8'hFF;
      m_sel      = 2'b11;
      m_nib_prev = 4'hF;
      m_dout     = 8'hFF;
      m_irq      = 1'b0;
      m_valid    = 1'b1;
    end else begin
      cur        = nib_of(m_db, m_sel);
      m_dout     = (rd_en && addr == 16'hFF00) ? {2'b11, m_sel, cur} : 8'hFF;
      m_irq      = |(m_nib_prev & ~cur);
      m_nib_prev = cur;
      if (wr_en && addr == 16'hFF00) m_sel = data_in[5:4];
      // The debouncer sees each raw line two edges late; released before that.
      raw_q.push_back(btn);
      seen = (raw_q.size() >= 3) ? raw_q[raw_q.size() - 3] : 8'hFF;
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      seen_q.push_back(seen);
      if (seen_q.size() > DB) void'(seen_q.pop_front());
      // A button flips once its last DB samples all disagree with the held state.
      if (seen_q.size() == DB) begin
        for (int b = 0; b < 8; b++) begin
          all_diff = 1'b1;
          foreach (seen_q[j]) if (seen_q[j][b] == m_db[b]) all_diff = 1'b0;
          if (all_diff) m_db[b] = ~m_db[b];
        end
      end
    end
  end

  always @(negedge cpu_clk) begin
    if (m_valid) begin
      check("model_dout", data_out, m_dout);
      check("model_irq", {7'b0, joy_irq}, {7'b0, m_irq});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge cpu_clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [7:0] exp);
    addr = 16'hFF00; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(name, data_out, exp);
  endtask

  initial begin
    rst = 1'b1; btn = 8'hFF; addr = '0; rd_en = 1'b0; wr_en = 1'b0; data_in = '0;
    tick(2);
    check("reset_dout", data_out, 8'hFF);
    check("reset_irq", {7'b0, joy_irq}, 8'h00);
    rst = 1'b0;
    do_read("reset_read", 8'hFF);

    // Debounce: a pressed with buttons selected; db changes on the 6th edge.
    do_write(16'hFF00, 8'h10);
    btn[B_A] = 1'b0;
    addr = 16'hFF00; rd_en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check($sformatf("deb_read_%0d", n), data_out, (n < 7) ? 8'hDF : 8'hDE);
      check($sformatf("deb_irq_%0d", n), {7'b0, joy_irq}, (n == 7) ? 8'h01 : 8'h00);
    end
    rd_en = 1'b0;
    do_read("deb_final", 8'hDE);

    // Glitch of 3 cycles on up with directions selected must not show.
    btn[B_A] = 1'b1;
    tick(8);
    do_write(16'hFF00, 8'h20);
    btn[R_UP] = 1'b0;
    tick(3);
    btn[R_UP] = 1'b1;
    addr = 16'hFF00; rd_en = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("glitch_read_%0d", n), data_out, 8'hEF);
      check($sformatf("glitch_irq_%0d", n), {7'b0, joy_irq}, 8'h00);
    end
    rd_en = 1'b0;

    // Both groups AND together; neither group reads all released.
    btn[R_RT] = 1'b0; btn[B_ST] = 1'b0;
    tick(8);
    do_write(16'hFF00, 8'h00);
    do_read("both_groups", 8'hC6);
    do_write(16'hFF00, 8'h30);
    do_read("no_group", 8'hFF);
    do_write(16'hFF01, 8'h00);
    do_read("other_addr_write", 8'hFF);

    // Select write exposing a held button fires the IRQ; deselecting does not.
    btn[R_RT] = 1'b1; btn[B_ST] = 1'b1; btn[R_DN] = 1'b0;
    tick(8);
    do_write(16'hFF00, 8'h20);
    check("sel_irq_w0", {7'b0, joy_irq}, 8'h00);
    tick();
    check("sel_irq_w1", {7'b0, joy_irq}, 8'h01);
    tick();
    check("sel_irq_w2", {7'b0, joy_irq}, 8'h00);
    do_read("sel_dirs_read", 8'hE7);
    do_write(16'hFF00, 8'h30);
    check("desel_irq_0", {7'b0, joy_irq}, 8'h00);
    tick();
    check("desel_irq_1", {7'b0, joy_irq}, 8'h00);

    // Simultaneous read and write returns the pre-write select.
    addr = 16'hFF00; data_in = 8'h20; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rdwr_same_cycle", data_out, 8'hFF);
    do_read("rdwr_after", 8'hE7);

    // Mid-operation reset clears everything with no IRQ afterwards.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_dout", data_out, 8'hFF);
    check("midrst_irq", {7'b0, joy_irq}, 8'h00);
    tick();
    check("midrst_irq_next", {7'b0, joy_irq}, 8'h00);
    do_read("midrst_read", 8'hFF);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/joypad_p1.md
Name: joypad_p1

Overview:
CPU-side receiver for the active-low joypad lines driven into the top level. It synchronizes and debounces the eight button inputs and exposes them through the P1 register at 0xFF00 using the DMG group-select scheme. It also raises the joypad interrupt request on any high-to-low transition of the selected input nibble. The block sits on the CPU memory bus next to the other I/O registers and feeds the interrupt controller.

Parameters:
DEBOUNCE_CYCLES, 4190, consecutive identical synchronized samples required before a button's debounced state changes (about 1 ms at 4.19 MHz); legal range 1..65535.
CNT_W, 16, width of each per-button debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
cpu_clk  input  1  CPU clock; all logic on its rising edge.
rst  input  1  synchronous active-high reset.
joypad_up  input  1  raw button line, active-low (0 = pressed), asynchronous to cpu_clk.
joypad_down  input  1  same as joypad_up.
joypad_left  input  1  same as joypad_up.
joypad_right  input  1  same as joypad_up.
joypad_a  input  1  same as joypad_up.
joypad_b  input  1  same as joypad_up.
joypad_start  input  1  same as joypad_up.
joypad_select  input  1  same as joypad_up.
addr  input  16  CPU bus address.
rd_en  input  1  read strobe, one cycle.
wr_en  input  1  write strobe, one cycle.
data_in  input  8  write data.
data_out  output  8  read data.
joy_irq  output  1  one-cycle interrupt request pulse (IF bit 4).

Behaviour:
- Clock and reset: one clock, cpu_clk. rst is synchronous and active-high.
- Synchronizer: each raw line passes through 2 flops. Reset value of every flop is 1.
- Debounce, per button:
  - The block holds a debounced state db (reset 1) and a counter cnt (reset 0).
  - If the synchronized sample equals db, cnt is set to 0.
  - Otherwise cnt increments. When cnt reaches DEBOUNCE_CYCLES-1, db takes the sample and cnt is set to 0.
  - Net effect: a clean input change is visible in db 2 + DEBOUNCE_CYCLES cycles after the edge.
  - A glitch shorter than DEBOUNCE_CYCLES is never visible.
- Select register sel[1:0] = P1 bits 5:4. Reset value is 2'b11 (no group selected).
  - Loaded from data_in[5:4] when wr_en=1 and addr=16'hFF00.
  - Other data bits are ignored. Writes to any other address are ignored.
- Nibble formation (combinational from db and sel):
  - sel[0]=0 (P14) selects directions: bit0 right, bit1 left, bit2 up, bit3 down.
  - sel[1]=0 (P15) selects buttons: bit0 a, bit1 b, bit2 select, bit3 start.
  - Both groups selected: nib = bitwise AND of the two groups.
  - Neither group selected: nib = 4'b1111.
- P1 read value = {2'b11, sel, nib}.
- Read timing:
  - data_out is registered, reset 8'hFF.
  - The cycle after rd_en=1 with addr=16'hFF00, data_out = P1 as it stood in the rd_en cycle.
  - The cycle after any other cycle (no read, or a read of another address), data_out = 8'hFF.
  - Simultaneous rd_en and wr_en to 0xFF00: the read returns the pre-write sel.
- Interrupt:
  - nib_q is a register (reset 4'b1111) holding the previous cycle's nib.
  - joy_irq is registered, reset 0. It is 1 for exactly one cycle, the cycle after any bit satisfies nib_q=1 and nib=0.
  - Falling edges caused by a select write also fire the interrupt.
  - Rising edges never fire it.
  - Multiple simultaneous falling bits produce one pulse.
- Reset mid-operation clears synchronizers, counters, db, sel, nib_q, data_out and joy_irq in the same edge. No interrupt fires on the first cycle after reset.

Test Plan:
- Reset: assert rst for 2 cycles with all buttons released -> data_out=8'hFF and joy_irq=0. A read of 0xFF00 then returns 8'hFF (sel=11, nib=1111).
- Debounce (DEBOUNCE_CYCLES=4): hold joypad_a=0, write 8'h10 to 0xFF00 (select buttons).
  - Nib goes 4'b1110 exactly 6 cycles after the edge, and joy_irq pulses once.
  - A read then returns 8'hDE.
- Glitch rejection (DEBOUNCE_CYCLES=4): pulse joypad_up low for 3 cycles with sel=10 -> the read stays 8'hEF and joy_irq never asserts.
- Both groups and neither group: hold right=0 and start=0.
  - Write 8'h00 -> the read returns 8'hC6.
  - Write 8'h30 -> the read returns 8'hFF.
- Select-triggered interrupt with down held:
  - Write 8'h20 (select directions) -> the read returns 8'hE7 and joy_irq pulses the cycle after nib changes.
  - Write 8'h30 -> no pulse.
- Simultaneous read and write: with down held and sel=11, issue rd_en+wr_en of 8'h20 in the same cycle -> data_out=8'hFF. The next read returns 8'hE7.
